// File: rtl/psk_symbol_serializer_if.sv
// FIFO-side and phase-generator-side signals of the PSK symbol serializer.
// fifo_data is valid whenever fifo_empty=0; the head word is consumed at the edge where fifo_read=1.
interface psk_symbol_serializer_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int BITS_PER_SYMBOL = 2
);
    logic                       enable;
    logic [DATA_WIDTH-1:0]      fifo_data;
    logic                       fifo_empty;
    logic                       fifo_read;
    logic [BITS_PER_SYMBOL-1:0] phase;
    logic                       sym_valid;
    logic                       sym_strobe;
    logic                       underrun;
    logic                       underrun_clr;

    modport master (
        input  enable, fifo_data, fifo_empty, underrun_clr,
        output fifo_read, phase, sym_valid, sym_strobe, underrun
    );

    modport slave (
        output enable, fifo_data, fifo_empty, underrun_clr,
        input  fifo_read, phase, sym_valid, sym_strobe, underrun
    );
endinterface

// File: rtl/psk_symbol_serializer.sv
// Slices FWFT FIFO words LSB-first into held M-PSK phase indices with optional
// Gray/differential mapping, word repeat and a sticky underrun flag.
module psk_symbol_serializer #(
    parameter int DATA_WIDTH      = 8,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int CLKS_PER_SYMBOL = 4,
    parameter int WORD_REPEAT     = 1,
    parameter int GRAY            = 0,
    parameter int DIFFERENTIAL    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    psk_symbol_serializer_if.master bus,
    output logic                   dbg_state
);
    localparam int B    = BITS_PER_SYMBOL;
    localparam int NSYM = DATA_WIDTH / BITS_PER_SYMBOL;
    localparam int CW   = (CLKS_PER_SYMBOL > 1) ? $clog2(CLKS_PER_SYMBOL) : 1;
    localparam int SW   = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int RW   = (WORD_REPEAT > 1) ? $clog2(WORD_REPEAT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SYMBOL - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(NSYM - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(WORD_REPEAT - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                state;
    logic [CW-1:0]         clk_cnt;
    logic [SW-1:0]         sym_cnt;
    logic [RW-1:0]         rep_cnt;
    logic [DATA_WIDTH-1:0] word;
    logic [B-1:0]          acc;
    logic [B-1:0]          phase_q;
    logic                  fifo_read_q;
    logic                  sym_strobe_q;
    logic                  sym_valid_q;
    logic                  underrun_q;

    logic                  clk_last, sym_last, rep_last;
    logic                  capture, do_load, fresh, underrun_evt;
    logic [DATA_WIDTH-1:0] src_word;
    logic [SW-1:0]         src_idx;
    logic [DATA_WIDTH-1:0] shifted;
    logic [B-1:0]          raw, mapped, acc_base, phase_new;

    assign clk_last = (clk_cnt == CLK_LAST);
    assign sym_last = (sym_cnt == SYM_LAST);
    assign rep_last = (rep_cnt == REP_LAST);

    // Decide what (if anything) is loaded into phase at the coming edge.
    always_comb begin
        capture      = 1'b0;
        do_load      = 1'b0;
        fresh        = 1'b0;
        underrun_evt = 1'b0;
        src_word     = word;
        src_idx      = '0;
        case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    capture  = 1'b1;
                    do_load  = 1'b1;
                    fresh    = 1'b1;
                    src_word = bus.fifo_data;
                end
            end
            RUN: begin
                if (clk_last) begin
                    if (!sym_last) begin
                        do_load = 1'b1;
                        src_idx = sym_cnt + SW'(1);
                    end else if (!rep_last) begin
                        do_load = 1'b1;
                    end else if (!bus.fifo_empty) begin
                        capture  = 1'b1;
                        do_load  = 1'b1;
                        src_word = bus.fifo_data;
                    end else begin
                        underrun_evt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // A new burst from IDLE restarts the differential accumulator at zero.
    assign shifted   = src_word >> (int'(src_idx) * B);
    assign raw       = shifted[B-1:0];
    assign mapped    = (GRAY != 0) ? (raw ^ (raw >> 1)) : raw;
    assign acc_base  = fresh ? '0 : acc;
    assign phase_new = (DIFFERENTIAL != 0) ? (acc_base + mapped) : mapped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            sym_cnt      <= '0;
            rep_cnt      <= '0;
            word         <= '0;
            acc          <= '0;
            phase_q      <= '0;
            fifo_read_q  <= 1'b0;
            sym_strobe_q <= 1'b0;
            sym_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (bus.enable) begin
            fifo_read_q  <= capture;
            sym_strobe_q <= do_load;
            if (do_load) begin
                phase_q <= phase_new;
                acc     <= (DIFFERENTIAL != 0) ? phase_new : '0;
            end
            if (underrun_evt) begin
                underrun_q <= 1'b1;
            end else if (bus.underrun_clr) begin
                underrun_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (capture) begin
                        word        <= bus.fifo_data;
                        clk_cnt     <= '0;
                        sym_cnt     <= '0;
                        rep_cnt     <= '0;
                        sym_valid_q <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!clk_last) begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end else begin
                        clk_cnt <= '0;
                        if (!sym_last) begin
                            sym_cnt <= sym_cnt + SW'(1);
                        end else begin
                            sym_cnt <= '0;
                            if (!rep_last) begin
                                rep_cnt <= rep_cnt + RW'(1);
                            end else begin
                                rep_cnt <= '0;
                                if (capture) begin
                                    word <= bus.fifo_data;
                                end else begin
                                    sym_valid_q <= 1'b0;
                                    state       <= IDLE;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pulses stay pending in their registers while disabled and show on the next enabled cycle.
    assign bus.fifo_read  = fifo_read_q & bus.enable & ~rst;
    assign bus.sym_strobe = sym_strobe_q & bus.enable & ~rst;
    assign bus.phase      = phase_q;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.underrun   = underrun_q;
    assign dbg_state      = (state == RUN);
endmodule

// File: tb/tb_psk_symbol_serializer.sv
// Directed bench for psk_symbol_serializer: four parameter variants share one clock,
// each fed by its own queue-modelled FWFT FIFO.
module tb_psk_symbol_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    psk_symbol_serializer_if #(.DATA_WIDTH(8), .BITS_PER_SYMBOL(2)) ifc0 ();
    psk_symbol_serializer_if #(.DATA_WIDTH(8), .BITS_PER_SYMBOL(2)) ifc1 ();
    psk_symbol_serializer_if #(.DATA_WIDTH(8), .BITS_PER_SYMBOL(2)) ifc2 ();
    psk_symbol_serializer_if #(.DATA_WIDTH(8), .BITS_PER_SYMBOL(2)) ifc3 ();
    logic st0, st1, st2, st3;

    psk_symbol_serializer #(.GRAY(0), .DIFFERENTIAL(0), .WORD_REPEAT(1))
        dut0 (.clk(clk), .rst(rst), .bus(ifc0.master), .dbg_state(st0));
    psk_symbol_serializer #(.GRAY(1), .DIFFERENTIAL(0), .WORD_REPEAT(1))
        dut1 (.clk(clk), .rst(rst), .bus(ifc1.master), .dbg_state(st1));
    psk_symbol_serializer #(.GRAY(0), .DIFFERENTIAL(1), .WORD_REPEAT(1))
        dut2 (.clk(clk), .rst(rst), .bus(ifc2.master), .dbg_state(st2));
    psk_symbol_serializer #(.GRAY(0), .DIFFERENTIAL(0), .WORD_REPEAT(3))
        dut3 (.clk(clk), .rst(rst), .bus(ifc3.master), .dbg_state(st3));

    logic [7:0]  q0[$], q1[$], q2[$], q3[$];
    logic [1:0]  exp_q[$];
    logic [31:0] ph_s[4], sv_s[4], ss_s[4], rd_s[4], ur_s[4], st_s[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic refresh();
        ifc0.fifo_data = (q0.size() != 0) ? q0[0] : 8'h00;
        ifc0.fifo_empty = (q0.size() == 0);
        ifc1.fifo_data = (q1.size() != 0) ? q1[0] : 8'h00;
        ifc1.fifo_empty = (q1.size() == 0);
        ifc2.fifo_data = (q2.size() != 0) ? q2[0] : 8'h00;
        ifc2.fifo_empty = (q2.size() == 0);
        ifc3.fifo_data = (q3.size() != 0) ? q3[0] : 8'h00;
        ifc3.fifo_empty = (q3.size() == 0);
    endtask

    task automatic push(input int inst, input logic [7:0] data);
        case (inst)
            0: q0.push_back(data);
            1: q1.push_back(data);
            2: q2.push_back(data);
            default: q3.push_back(data);
        endcase
        refresh();
    endtask

    task automatic drive(input int inst, input logic en, input logic clr);
        case (inst)
            0: begin ifc0.enable = en; ifc0.underrun_clr = clr; end
            1: begin ifc1.enable = en; ifc1.underrun_clr = clr; end
            2: begin ifc2.enable = en; ifc2.underrun_clr = clr; end
            default: begin ifc3.enable = en; ifc3.underrun_clr = clr; end
        endcase
    endtask

    // Pops use the fifo_read level seen in the cycle before this edge.
    task automatic cycle_edge();
        @(posedge clk);
        #1;
        if (rd_s[0][0] && q0.size() != 0) q0.delete(0);
        if (rd_s[1][0] && q1.size() != 0) q1.delete(0);
        if (rd_s[2][0] && q2.size() != 0) q2.delete(0);
        if (rd_s[3][0] && q3.size() != 0) q3.delete(0);
        refresh();
    endtask

    task automatic sample();
        @(negedge clk);
        ph_s[0] = 32'(ifc0.phase); sv_s[0] = 32'(ifc0.sym_valid); ss_s[0] = 32'(ifc0.sym_strobe);
        rd_s[0] = 32'(ifc0.fifo_read); ur_s[0] = 32'(ifc0.underrun); st_s[0] = 32'(st0);
        ph_s[1] = 32'(ifc1.phase); sv_s[1] = 32'(ifc1.sym_valid); ss_s[1] = 32'(ifc1.sym_strobe);
        rd_s[1] = 32'(ifc1.fifo_read); ur_s[1] = 32'(ifc1.underrun); st_s[1] = 32'(st1);
        ph_s[2] = 32'(ifc2.phase); sv_s[2] = 32'(ifc2.sym_valid); ss_s[2] = 32'(ifc2.sym_strobe);
        rd_s[2] = 32'(ifc2.fifo_read); ur_s[2] = 32'(ifc2.underrun); st_s[2] = 32'(st2);
        ph_s[3] = 32'(ifc3.phase); sv_s[3] = 32'(ifc3.sym_valid); ss_s[3] = 32'(ifc3.sym_strobe);
        rd_s[3] = 32'(ifc3.fifo_read); ur_s[3] = 32'(ifc3.underrun); st_s[3] = 32'(st3);
    endtask

    // Expected phase list, packed LSB-first two bits per symbol.
    task automatic set_exp(input logic [47:0] syms, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(syms[2*i +: 2]);
    endtask

    // Runs one burst from the capture edge until the underrun cycle. u counts enabled
    // edges since capture; enable is dropped for cycles [fa,fa+la) and [fb,fb+lb).
    task automatic run_stream(input string name, input int inst, input int nsym,
                              input int rd_every, input int fa, input int la,
                              input int fb, input int lb, input bit clr_last);
        int u = 0;
        int c = 0;
        int reads = 0;
        int strobes = 0;
        bit en_prev = 1'b1;
        bit en_now;
        bit done = 1'b0;
        while (!done && c < 400) begin
            cycle_edge();
            if (c > 0 && en_prev) u++;
            en_now = !((c >= fa && c < fa + la) || (c >= fb && c < fb + lb));
            drive(inst, en_now, clr_last && en_now && (u == nsym * 4 - 1));
            sample();
            if (u < nsym * 4) begin
                check({name, " sym_valid"}, sv_s[inst], 32'd1);
                check({name, " phase"}, ph_s[inst], 32'(exp_q[u / 4]));
                check({name, " sym_strobe"}, ss_s[inst], (en_now && u % 4 == 0) ? 32'd1 : 32'd0);
                check({name, " fifo_read"}, rd_s[inst], (en_now && u % rd_every == 0) ? 32'd1 : 32'd0);
            end else begin
                check({name, " end sym_valid"}, sv_s[inst], 32'd0);
                check({name, " end underrun"}, ur_s[inst], 32'd1);
                check({name, " end phase held"}, ph_s[inst], 32'(exp_q[nsym - 1]));
                check({name, " end state idle"}, st_s[inst], 32'd0);
                done = 1'b1;
            end
            reads += int'(rd_s[inst]);
            strobes += int'(ss_s[inst]);
            en_prev = en_now;
            c++;
        end
        if (!done) check({name, " timeout"}, 32'd0, 32'd1);
        drive(inst, 1'b1, 1'b0);
        check({name, " pop count"}, 32'(reads), 32'(nsym * 4 / rd_every));
        check({name, " strobe count"}, 32'(strobes), 32'(nsym));
        check({name, " duration"}, 32'(c), 32'(nsym * 4 + 1 + la + lb));
    endtask

    initial begin
        int reads;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_s[i] = '0;
        end
        refresh();
        repeat (3) begin cycle_edge(); sample(); end
        cycle_edge();
        rst = 1'b0;
        sample();
        for (int i = 0; i < 4; i++) begin
            check("reset phase", ph_s[i], 32'd0);
            check("reset sym_valid", sv_s[i], 32'd0);
            check("reset sym_strobe", ss_s[i], 32'd0);
            check("reset fifo_read", rd_s[i], 32'd0);
            check("reset underrun", ur_s[i], 32'd0);
            check("reset state", st_s[i], 32'd0);
        end

        // Plain mapping, word 0xE4 -> 0,1,2,3
        set_exp(48'hE4, 4);
        push(0, 8'hE4);
        run_stream("t1 plain", 0, 4, 16, -1, 0, -1, 0, 1'b0);

        // Gray mapping, word 0xE4 -> 0,1,3,2
        set_exp(48'hB4, 4);
        push(1, 8'hE4);
        run_stream("t2 gray", 1, 4, 16, -1, 0, -1, 0, 1'b0);

        // Differential, two back-to-back 0x55 words -> 1,2,3,0,1,2,3,0
        set_exp(48'h3939, 8);
        push(2, 8'h55);
        push(2, 8'h55);
        run_stream("t2 diff", 2, 8, 16, -1, 0, -1, 0, 1'b0);

        // Repeat 3: 0xE4 x3 then 0x1B x3, one pop per word
        set_exp(48'h1B1B1B_E4E4E4, 24);
        push(3, 8'hE4);
        push(3, 8'h1B);
        run_stream("t3 repeat", 3, 24, 48, -1, 0, -1, 0, 1'b0);

        // Enable drops: right after capture (deferred pop/strobe), then 5 cycles at clk_cnt=2 of symbol 1
        set_exp(48'hE4, 4);
        push(0, 8'hE4);
        run_stream("t4 freeze", 0, 4, 16, 0, 2, 8, 5, 1'b0);

        // Underrun clear alone, then set-and-clear together, then restart with acc=0
        check("t5 underrun before clr", ur_s[2], 32'd1);
        cycle_edge(); drive(2, 1'b1, 1'b1); sample();
        cycle_edge(); drive(2, 1'b1, 1'b0); sample();
        check("t5 clr alone", ur_s[2], 32'd0);
        set_exp(48'h55, 4);
        push(2, 8'h01);
        run_stream("t5 set wins", 2, 4, 16, -1, 0, -1, 0, 1'b1);
        cycle_edge(); drive(2, 1'b1, 1'b1); sample();
        cycle_edge(); drive(2, 1'b1, 1'b0); sample();
        check("t5 clr alone again", ur_s[2], 32'd0);
        push(2, 8'h01);
        run_stream("t5 acc restart", 2, 4, 16, -1, 0, -1, 0, 1'b0);

        // Reset while the capture pop is pending: no pop, word stays queued
        push(0, 8'hE4);
        cycle_edge(); rst = 1'b1; sample();
        check("t6 pending read cancelled", rd_s[0], 32'd0);
        cycle_edge(); rst = 1'b0; sample();
        check("t6 no pop under reset", 32'(q0.size()), 32'd1);
        check("t6 rst sym_valid", sv_s[0], 32'd0);
        check("t6 rst state", st_s[0], 32'd0);
        set_exp(48'hE4, 4);
        run_stream("t6 after cancel", 0, 4, 16, -1, 0, -1, 0, 1'b0);

        // Reset mid-symbol 2 of 0xE4
        push(0, 8'hE4);
        reads = 0;
        for (int k = 0; k < 10; k++) begin
            cycle_edge();
            if (k == 9) rst = 1'b1;
            sample();
            if (k == 8) check("t6 in symbol 2", ph_s[0], 32'd2);
            reads += int'(rd_s[0]);
        end
        cycle_edge(); rst = 1'b0; sample();
        check("t6 mid rst phase", ph_s[0], 32'd0);
        check("t6 mid rst sym_valid", sv_s[0], 32'd0);
        check("t6 mid rst sym_strobe", ss_s[0], 32'd0);
        check("t6 mid rst fifo_read", rd_s[0], 32'd0);
        check("t6 mid rst underrun", ur_s[0], 32'd0);
        check("t6 mid rst state", st_s[0], 32'd0);
        cycle_edge(); sample();
        reads += int'(rd_s[0]);
        check("t6 single pop", 32'(reads), 32'd1);
        check("t6 idle stays", sv_s[0], 32'd0);
        set_exp(48'h1B, 4);
        push(0, 8'h1B);
        run_stream("t6 clean restart", 0, 4, 16, -1, 0, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
